alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter ALU_LAT, default 1, meaning ALU settle cycles before result capture, legal range 1..4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have ports reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 SHALL have ports reqN_ready  output  1  arbiter accepts requester N this cycle.
REQ-006 SHALL have ports reqN_a, reqN_b  input  6  operands; reqN_op  input  2  (00 ADD, 01 SUB, 10 MUL, 11 AND); reqN_cin  input  1  carry/borrow in.
REQ-007 SHALL have ports alu_a, alu_b  output  6; alu_sel  output  2; alu_cin  output  1  registered drive to the shared ALU.
REQ-008 SHALL have ports alu_result  input  12; alu_cout  input  1  ALU outputs.
REQ-009 SHALL have ports rsp_valid  output  1; rsp_ready  input  1; rsp_id  output  1  (owning requester); rsp_result  output  12; rsp_cout  output  1.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement three states: IDLE, EXEC, RESP.
REQ-012 In IDLE, grant SHALL be combinational: only one valid -> that requester; both valid -> requester not granted last (rr pointer); after reset pointer favours requester 0.
REQ-013 reqN_ready SHALL be high only in IDLE and only for the granted requester; never both high.
REQ-014 Transfer SHALL occur on edge where reqN_valid & reqN_ready; then operands/op/cin latch into alu_* registers, rsp_id <= N, rr pointer updates to N, state -> EXEC, wait counter <= 0.
REQ-015 In EXEC counter SHALL increment each cycle; on edge where counter == ALU_LAT-1, rsp_result <= alu_result, rsp_cout <= alu_cout, state -> RESP.
REQ-016 Latency SHALL be exactly ALU_LAT+1 edges from accept edge to rsp_valid high.
REQ-017 In RESP rsp_valid SHALL be high; rsp_result, rsp_cout, rsp_id SHALL hold stable until rsp_valid & rsp_ready edge, then state -> IDLE.
REQ-018 No bypass: new request SHALL be accepted no earlier than the cycle following the response transfer edge.
REQ-019 alu_* SHALL hold last issued values outside EXEC; requester inputs changing during EXEC/RESP SHALL have no effect.
REQ-020 reqN_valid dropping in IDLE before transfer SHALL cause no action; arbiter SHALL not require valid to be sticky.
REQ-021 rsp_result SHALL pass full 12-bit alu_result unmodified (MUL uses all 12 bits; ADD/SUB/AND lower 6 valid, upper bits as ALU drives).
REQ-022 Requests with both valid held continuously SHALL alternate 0,1,0,1 (no starvation).

Reset
REQ-023 On rst_n low, immediately: state IDLE, rr pointer favours 0, counter 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_cout 0, alu_a/alu_b/alu_sel/alu_cin 0, busy 0.
REQ-024 Reset mid-EXEC or mid-RESP SHALL discard the in-flight operation with no response generated.
REQ-025 First acceptance SHALL be possible on first rising edge after rst_n deasserts.

Verification
REQ-026 ALU_LAT=1, req0 ADD a=5 b=3 cin=0, rsp_ready=1 -> rsp_valid 2 edges after accept, rsp_id=0, rsp_result[5:0]=8, rsp_cout=0.
REQ-027 Both valid after reset: req0 ADD 63+1 cin=1, req1 SUB 10-6 cin=0 -> first rsp_id=0 result[5:0]=1 cout=1, second rsp_id=1 result[5:0]=4 cout=0.
REQ-028 req1 MUL 63*63, rsp_ready held low 5 cycles -> rsp_valid and rsp_result=3969 stable throughout, reqN_ready low, busy high; transfer on rsp_ready.
REQ-029 Both valid held 6 transactions -> rsp_id sequence 0,1,0,1,0,1.
REQ-030 rst_n pulsed low during EXEC of req0 AND 110011&101010 -> all outputs at reset values, no response; post-reset req0 AND 111111&111111 -> result[5:0]=111111.
REQ-031 ALU_LAT=4, req0 SUB 2-4 -> rsp_valid exactly 5 edges after accept, result[5:0]=111110, cout=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared multi-cycle ALU
`timescale 1ns/1ps
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [5:0]  req0_a,
  input  logic [5:0]  req0_b,
  input  logic [1:0]  req0_op,
  input  logic        req0_cin,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [5:0]  req1_a,
  input  logic [5:0]  req1_b,
  input  logic [1:0]  req1_op,
  input  logic        req1_cin,
  output logic [5:0]  alu_a,
  output logic [5:0]  alu_b,
  output logic [1:0]  alu_sel,
  output logic        alu_cin,
  input  logic [11:0] alu_result,
  input  logic        alu_cout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [11:0] rsp_result,
  output logic        rsp_cout,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       prio;      // requester favoured when both are valid
  logic [1:0] cnt;       // ALU settle cycles elapsed in EXEC (ALU_LAT <= 4)
  logic       grant0;
  logic       grant1;
  logic       cnt_done;

  // A lone valid wins outright; a tie goes to the requester not served last.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | ~prio);
    grant1 = req1_valid & (~req0_valid |  prio);
  end

  assign cnt_done  = (cnt == 2'(ALU_LAT - 1));
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and ready handshakes; readies only ever assert in IDLE.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      S_IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 | grant1) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (cnt_done) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand issue on accept, settle counting, result capture and rr pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      alu_cin    <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
      prio       <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant0) begin
            alu_a   <= req0_a;
            alu_b   <= req0_b;
            alu_sel <= req0_op;
            alu_cin <= req0_cin;
            rsp_id  <= 1'b0;
            prio    <= 1'b1;
            cnt     <= '0;
          end else if (grant1) begin
            alu_a   <= req1_a;
            alu_b   <= req1_b;
            alu_sel <= req1_op;
            alu_cin <= req1_cin;
            rsp_id  <= 1'b1;
            prio    <= 1'b0;
            cnt     <= '0;
          end
        end
        S_EXEC: begin
          cnt <= cnt + 2'd1;
          if (cnt_done) begin
            rsp_result <= alu_result;
            rsp_cout   <= alu_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter
`timescale 1ns/1ps
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  // ALU_LAT = 1 instance
  logic        req0_valid, req0_ready, req0_cin, req1_valid, req1_ready, req1_cin;
  logic [5:0]  req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
  logic [1:0]  req0_op, req1_op, alu_sel;
  logic        alu_cin, alu_cout, rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
  logic [11:0] alu_result, rsp_result;
  // ALU_LAT = 4 instance
  logic        f_req0_valid, f_req0_ready, f_req0_cin, f_req1_valid, f_req1_ready, f_req1_cin;
  logic [5:0]  f_req0_a, f_req0_b, f_req1_a, f_req1_b, f_alu_a, f_alu_b;
  logic [1:0]  f_req0_op, f_req1_op, f_alu_sel;
  logic        f_alu_cin, f_alu_cout, f_rsp_valid, f_rsp_ready, f_rsp_id, f_rsp_cout, f_busy;
  logic [11:0] f_alu_result, f_rsp_result;

  int          n_pass = 0;
  int          n_total = 0;
  bit          fav;             // model: requester that wins the next tie
  logic [13:0] sb[$];           // model: {id, cout, result} per accepted request

  // Behavioural ALU: {cout, 12-bit result}; upper bits of non-MUL ops carry ~a
  function automatic logic [12:0] ref_alu(input logic [1:0] op, input logic [5:0] a,
                                          input logic [5:0] b, input logic cin);
    int s;
    logic [11:0] r;
    logic c;
    s = 0; r = '0; c = 1'b0;
    case (op)
      2'd0: begin s = int'(a) + int'(b) + int'(cin); r = {~a, 6'(s)}; c = (s > 63); end
      2'd1: begin s = int'(a) - int'(b) - int'(cin); r = {~a, 6'(s)}; c = (s < 0); end
      2'd2: begin r = 12'(int'(a) * int'(b)); c = 1'b0; end
      default: begin r = {~a, a & b}; c = 1'b0; end
    endcase
    return {c, r};
  endfunction

  assign {alu_cout, alu_result}     = ref_alu(alu_sel, alu_a, alu_b, alu_cin);
  assign {f_alu_cout, f_alu_result} = ref_alu(f_alu_sel, f_alu_a, f_alu_b, f_alu_cin);

  alu_arbiter #(.ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_cin(req1_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .busy(busy)
  );

  alu_arbiter #(.ALU_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_a(f_req0_a), .req0_b(f_req0_b),
    .req0_op(f_req0_op), .req0_cin(f_req0_cin),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_a(f_req1_a), .req1_b(f_req1_b),
    .req1_op(f_req1_op), .req1_cin(f_req1_cin),
    .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_sel(f_alu_sel), .alu_cin(f_alu_cin),
    .alu_result(f_alu_result), .alu_cout(f_alu_cout),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_id(f_rsp_id),
    .rsp_result(f_rsp_result), .rsp_cout(f_rsp_cout), .busy(f_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic rand_req(input int id);
    if (id == 0) begin
      req0_a = 6'($urandom); req0_b = 6'($urandom); req0_op = 2'($urandom); req0_cin = 1'($urandom);
    end else begin
      req1_a = 6'($urandom); req1_b = 6'($urandom); req1_op = 2'($urandom); req1_cin = 1'($urandom);
    end
  endtask

  task automatic apply_reset();
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    f_req0_valid = 0; f_req1_valid = 0; f_rsp_ready = 0;
    @(negedge clk); rst_n = 0;
    @(negedge clk); @(negedge clk); rst_n = 1;
    fav = 0;
    sb.delete();
  endtask

  // Waits (bounded) for a transfer edge; returns just after that edge.
  task automatic wait_accept(output int id, output bit ok);
    ok = 0; id = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (req0_valid && req0_ready) begin
        ok = 1; id = 0; sb.push_back({1'b0, ref_alu(req0_op, req0_a, req0_b, req0_cin)});
      end else if (req1_valid && req1_ready) begin
        ok = 1; id = 1; sb.push_back({1'b1, ref_alu(req1_op, req1_a, req1_b, req1_cin)});
      end
      @(posedge clk); #1;
    end
  endtask

  // Counts edges from the accept edge (inclusive) until rsp_valid is seen.
  task automatic wait_rsp(output int edges, output bit ok);
    ok = 0; edges = 1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      edges++;
      if (rsp_valid) ok = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    f_req0_valid = 0; f_req1_valid = 0; f_rsp_ready = 0;
    rand_req(0); rand_req(1);
    f_req0_a = 0; f_req0_b = 0; f_req0_op = 0; f_req0_cin = 0;
    f_req1_a = 0; f_req1_b = 0; f_req1_op = 0; f_req1_cin = 0;
    #3;
    n_total++;
    if ({rsp_valid, busy, rsp_id, rsp_result, rsp_cout, alu_a, alu_b, alu_sel, alu_cin, req0_ready, req1_ready} !== '0)
      $display("FAIL reset_state: got rv=%b busy=%b id=%b res=%h c=%b a=%h b=%h sel=%h cin=%b, want all 0",
               rsp_valid, busy, rsp_id, rsp_result, rsp_cout, alu_a, alu_b, alu_sel, alu_cin);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({f_rsp_valid, f_busy, f_rsp_id, f_rsp_result, f_rsp_cout, f_alu_a, f_alu_b, f_alu_sel, f_alu_cin} !== '0)
      $display("FAIL reset_state_lat4: got rv=%b busy=%b res=%h, want all 0", f_rsp_valid, f_busy, f_rsp_result);
    else n_pass++;
  endtask

  task automatic test_basic();
    int id, edges; bit ok; logic [13:0] exp;
    apply_reset();
    req0_op = 2'd0; req0_a = 6'd5; req0_b = 6'd3; req0_cin = 0; req0_valid = 1; rsp_ready = 1;
    wait_accept(id, ok);
    req0_valid = 0;
    n_total++;
    if (!ok || id != 0) $display("FAIL basic_accept: got ok=%0d id=%0d, want ok=1 id=0", ok, id); else n_pass++;
    wait_rsp(edges, ok);
    n_total++;
    if (!ok || edges != 2) $display("FAIL basic_latency: got ok=%0d edges=%0d, want 2", ok, edges); else n_pass++;
    exp = sb.pop_front();
    n_total++;
    if (rsp_id !== 1'b0 || rsp_result[5:0] !== 6'd8 || rsp_cout !== 1'b0 || {rsp_id, rsp_cout, rsp_result} !== exp)
      $display("FAIL basic_result: got id=%b res=%h c=%b, want id=0 res=%h c=0", rsp_id, rsp_result, rsp_cout, exp[11:0]);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL basic_release: got rv=%b busy=%b, want 0 0", rsp_valid, busy);
    else n_pass++;
  endtask

  task automatic test_both();
    int id, edges, want; bit ok; logic [13:0] exp;
    logic [5:0] lo[2];
    logic       co[2];
    lo[0] = 6'd1; lo[1] = 6'd4; co[0] = 1'b1; co[1] = 1'b0;
    apply_reset();
    req0_op = 2'd0; req0_a = 6'd63; req0_b = 6'd1;  req0_cin = 1;
    req1_op = 2'd1; req1_a = 6'd10; req1_b = 6'd6; req1_cin = 0;
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    for (int t = 0; t < 2; t++) begin
      want = (req0_valid && req1_valid) ? int'(fav) : (req0_valid ? 0 : 1);
      wait_accept(id, ok);
      fav = (id == 0);
      if (id == 0) req0_valid = 0; else req1_valid = 0;
      wait_rsp(edges, ok);
      exp = sb.pop_front();
      n_total++;
      if (!ok || id != want || rsp_id !== 1'(t) || rsp_result[5:0] !== lo[t] || rsp_cout !== co[t] ||
          {rsp_id, rsp_cout, rsp_result} !== exp)
        $display("FAIL both_txn%0d: got id=%b res=%h c=%b, want id=%0d res[5:0]=%h c=%b", t, rsp_id, rsp_result,
                 rsp_cout, t, lo[t], co[t]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    int id, edges; bit ok; logic [13:0] exp;
    req0_valid = 0;
    req1_op = 2'd2; req1_a = 6'd63; req1_b = 6'd63; req1_cin = 0; req1_valid = 1; rsp_ready = 0;
    wait_accept(id, ok);
    fav = (id == 0);
    rand_req(0); rand_req(1); req0_valid = 1;   // inputs churn while the op is in flight
    wait_rsp(edges, ok);
    n_total++;
    if (!ok || id != 1) $display("FAIL stall_accept: got ok=%0d id=%0d, want id=1", ok, id); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      req1_valid = 1;
      n_total++;
      if (rsp_valid !== 1'b1 || rsp_result !== 12'd3969 || rsp_id !== 1'b1 || req0_ready !== 1'b0 ||
          req1_ready !== 1'b0 || busy !== 1'b1 || alu_a !== 6'd63 || alu_b !== 6'd63)
        $display("FAIL stall_hold%0d: got rv=%b res=%0d id=%b rdy=%b%b busy=%b alu_a=%0d, want 1 3969 1 00 1 63",
                 k, rsp_valid, rsp_result, rsp_id, req0_ready, req1_ready, busy, alu_a);
      else n_pass++;
    end
    exp = sb.pop_front();
    n_total++;
    if ({rsp_id, rsp_cout, rsp_result} !== exp) $display("FAIL stall_sb: got %h want %h", {rsp_id, rsp_cout, rsp_result}, exp);
    else n_pass++;
    rsp_ready = 1;
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    n_total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL stall_release: got rv=%b busy=%b, want 0 0", rsp_valid, busy);
    else n_pass++;
  endtask

  task automatic test_drop();
    rand_req(0);
    @(negedge clk); req0_valid = 1;
    #2 req0_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_total++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL drop_idle%0d: got busy=%b rv=%b, want 0 0", k, busy, rsp_valid);
      else n_pass++;
    end
  endtask

  task automatic test_alternate();
    int id, edges, d, want; bit ok; logic [13:0] exp;
    apply_reset();
    rand_req(0); rand_req(1);
    req0_valid = 1; req1_valid = 1;
    for (int t = 0; t < 6; t++) begin
      want = int'(fav);
      wait_accept(id, ok);
      fav = (id == 0);
      rand_req(id);
      n_total++;
      if (!ok || id != (t % 2) || id != want) $display("FAIL alt_order%0d: got id=%0d, want %0d", t, id, t % 2);
      else n_pass++;
      wait_rsp(edges, ok);
      exp = sb.pop_front();
      n_total++;
      if (!ok || edges != 2 || {rsp_id, rsp_cout, rsp_result} !== exp)
        $display("FAIL alt_rsp%0d: got edges=%0d {id,c,res}=%h, want 2 %h", t, edges, {rsp_id, rsp_cout, rsp_result}, exp);
      else n_pass++;
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        @(posedge clk); #1;
        n_total++;
        if (rsp_valid !== 1'b1 || {rsp_id, rsp_cout, rsp_result} !== exp)
          $display("FAIL alt_hold%0d: got rv=%b %h, want 1 %h", t, rsp_valid, {rsp_id, rsp_cout, rsp_result}, exp);
        else n_pass++;
      end
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_reset_mid();
    int id, edges; bit ok; logic [13:0] exp;
    rsp_ready = 1;
    req0_op = 2'd3; req0_a = 6'b110011; req0_b = 6'b101010; req0_cin = 0; req0_valid = 1;
    wait_accept(id, ok);
    req0_valid = 0;
    #2 rst_n = 0;
    #1;
    sb.delete(); fav = 0;
    n_total++;
    if (!ok || {rsp_valid, busy, rsp_id, rsp_result, rsp_cout, alu_a, alu_b, alu_sel, alu_cin} !== '0)
      $display("FAIL midreset_state: got rv=%b busy=%b res=%h alu_a=%h sel=%h, want all 0", rsp_valid, busy,
               rsp_result, alu_a, alu_sel);
    else n_pass++;
    req0_op = 2'd3; req0_a = 6'h3f; req0_b = 6'h3f; req0_valid = 1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_total++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL midreset_hold%0d: got rv=%b busy=%b, want 0 0", k, rsp_valid, busy);
      else n_pass++;
    end
    @(negedge clk); rst_n = 1;
    sb.push_back({1'b0, ref_alu(req0_op, req0_a, req0_b, req0_cin)});
    @(posedge clk); #1;
    req0_valid = 0;
    n_total++;
    if (busy !== 1'b1 || alu_a !== 6'h3f || alu_b !== 6'h3f || alu_sel !== 2'd3)
      $display("FAIL first_edge_accept: got busy=%b a=%h b=%h sel=%h, want 1 3f 3f 3", busy, alu_a, alu_b, alu_sel);
    else n_pass++;
    wait_rsp(edges, ok);
    exp = sb.pop_front();
    n_total++;
    if (!ok || rsp_id !== 1'b0 || rsp_result[5:0] !== 6'h3f || {rsp_id, rsp_cout, rsp_result} !== exp)
      $display("FAIL midreset_new: got id=%b res=%h, want id=0 res[5:0]=3f", rsp_id, rsp_result);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_lat4();
    int edges, id; bit ok; logic [12:0] e;
    logic [5:0] a, b; logic [1:0] op; logic cin;
    f_rsp_ready = 1;
    for (int t = 0; t < 4; t++) begin
      if (t == 0) begin id = 0; op = 2'd1; a = 6'd2; b = 6'd4; cin = 0; end
      else begin id = $urandom_range(0, 1); op = 2'($urandom); a = 6'($urandom); b = 6'($urandom); cin = 1'($urandom); end
      e = ref_alu(op, a, b, cin);
      if (id == 0) begin f_req0_op = op; f_req0_a = a; f_req0_b = b; f_req0_cin = cin; f_req0_valid = 1; end
      else begin f_req1_op = op; f_req1_a = a; f_req1_b = b; f_req1_cin = cin; f_req1_valid = 1; end
      #1;
      n_total++;
      if ((id == 0 ? f_req0_ready : f_req1_ready) !== 1'b1) $display("FAIL lat4_ready%0d: got 0, want 1", t);
      else n_pass++;
      @(posedge clk); #1;
      f_req0_valid = 0; f_req1_valid = 0;
      ok = 0; edges = 1;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(posedge clk); #1;
        edges++;
        if (f_rsp_valid) ok = 1;
      end
      n_total++;
      if (!ok || edges != 5 || {f_rsp_id, f_rsp_cout, f_rsp_result} !== {1'(id), e} ||
          (t == 0 && (f_rsp_result[5:0] !== 6'b111110 || f_rsp_cout !== 1'b1)))
        $display("FAIL lat4_txn%0d: got ok=%0d edges=%0d {id,c,res}=%h, want edges=5 %h", t, ok, edges,
                 {f_rsp_id, f_rsp_cout, f_rsp_result}, {1'(id), e});
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_both();
    test_stall();
    test_drop();
    test_alternate();
    test_reset_mid();
    test_lat4();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
